// File: rtl/code_sequencer.sv
// code_sequencer: walks the ROM pointer table and plays each code through
// the chirp controller. It arbitrates the shared ROM read port, inserts an
// inter-code gap, and handles abort, start timeout and controller failure.
// Optional macro SEQ_LOOP_EN: replay the table endlessly instead of ending
// in DONE after the last code.
//
// Ports:
//   clock_in, reset_n_in         clock, async active-low reset
//   start_in, abort_in           start request (edge), abort (level)
//   busy_out, done_out, fail_out status; led_out high while a code plays
//   code_index_out               index of the current code
//   mem_address_out, mem_data_in shared ROM port (async read)
//   ctrl_mem_address_in          controller's ROM address request
//   ctrl_base_address_out        code start address for the controller
//   ctrl_start_out/abort_out     one-cycle controller strobes
//   ctrl_busy_in, ctrl_fail_in   controller status
module code_sequencer #(
    parameter int ADDRESS_BITS  = 13,
    parameter int CLK_MHZ       = 8,
    parameter int GAP_US        = 250000,
    parameter int TABLE_BASE    = 0,
    parameter int START_TIMEOUT = 15
) (
    input  logic                    clock_in,
    input  logic                    reset_n_in,
    input  logic                    start_in,
    input  logic                    abort_in,
    output logic                    busy_out,
    output logic                    done_out,
    output logic                    fail_out,
    output logic                    led_out,
    output logic [7:0]              code_index_out,
    output logic [ADDRESS_BITS-1:0] mem_address_out,
    input  logic [7:0]              mem_data_in,
    input  logic [ADDRESS_BITS-1:0] ctrl_mem_address_in,
    output logic [ADDRESS_BITS-1:0] ctrl_base_address_out,
    output logic                    ctrl_start_out,
    output logic                    ctrl_abort_out,
    input  logic                    ctrl_busy_in,
    input  logic                    ctrl_fail_in
);

    localparam int GAP_CYCLES = GAP_US * CLK_MHZ;
    localparam int GAP_BITS   = $clog2(GAP_CYCLES + 1);
    localparam int TO_BITS    = $clog2(START_TIMEOUT + 1);

    localparam logic [GAP_BITS-1:0] GAP_LOAD = GAP_BITS'(GAP_CYCLES - 1);
    localparam logic [TO_BITS-1:0]  TO_LIMIT = TO_BITS'(START_TIMEOUT);
    localparam logic [ADDRESS_BITS-1:0] TBL_ADDR = ADDRESS_BITS'(TABLE_BASE);
    localparam logic [ADDRESS_BITS-1:0] ONE_ADDR = ADDRESS_BITS'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_READ_COUNT,
        S_READ_PTR_LO,
        S_READ_PTR_HI,
        S_START,
        S_WAIT_BUSY,
        S_RUN,
        S_GAP,
        S_DONE,
        S_FAIL
    } state_e;

    state_e                  state_q, state_d;
    logic                    start_q;
    logic [7:0]              count_q, count_d;
    logic [7:0]              index_q, index_d;
    logic [7:0]              lo_q, lo_d;
    logic [ADDRESS_BITS-1:0] base_q, base_d;
    logic [GAP_BITS-1:0]     gap_q, gap_d;
    logic [TO_BITS-1:0]      timeout_q, timeout_d;

    logic                    start_edge;
    logic                    abort_req;
    logic [7:0]              index_inc;
    logic [TO_BITS-1:0]      timeout_inc;
    logic [8:0]              index_x2;
    logic [15:0]             ptr_word;
    logic [ADDRESS_BITS-1:0] ptr_addr;
    logic [ADDRESS_BITS-1:0] own_addr;

    assign start_edge  = start_in & ~start_q;
    // Abort only applies while a run is in progress.
    assign abort_req   = abort_in && (state_q != S_IDLE) && (state_q != S_FAIL);
    assign index_inc   = index_q + 8'd1;
    assign timeout_inc = timeout_q + 1'b1;
    assign index_x2    = {index_q, 1'b0};
    assign ptr_word    = {mem_data_in, lo_q};
    assign ptr_addr    = TBL_ADDR + ONE_ADDR + ADDRESS_BITS'(index_x2);

    // State register and datapath flops
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            count_q   <= '0;
            index_q   <= '0;
            lo_q      <= '0;
            base_q    <= '0;
            gap_q     <= '0;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_in;
            count_q   <= count_d;
            index_q   <= index_d;
            lo_q      <= lo_d;
            base_q    <= base_d;
            gap_q     <= gap_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        lo_d      = lo_q;
        base_d    = base_q;
        gap_d     = gap_q;
        timeout_d = timeout_q;
        if (abort_req) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_edge) state_d = S_READ_COUNT;
                end
                S_READ_COUNT: begin
                    count_d = mem_data_in;
                    index_d = '0;
                    if (mem_data_in == 8'd0) state_d = S_DONE;
                    else                     state_d = S_READ_PTR_LO;
                end
                S_READ_PTR_LO: begin
                    lo_d    = mem_data_in;
                    state_d = S_READ_PTR_HI;
                end
                S_READ_PTR_HI: begin
                    base_d  = ADDRESS_BITS'(ptr_word);
                    state_d = S_START;
                end
                S_START: begin
                    timeout_d = '0;
                    state_d   = S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (ctrl_busy_in) begin
                        state_d = S_RUN;
                    end else begin
                        timeout_d = timeout_inc;
                        if (timeout_inc == TO_LIMIT) state_d = S_FAIL;
                    end
                end
                S_RUN: begin
                    // A failure reported as busy drops is still a failure.
                    if (ctrl_fail_in) begin
                        state_d = S_FAIL;
                    end else if (!ctrl_busy_in) begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q != '0) begin
                        gap_d = gap_q - 1'b1;
                    end else if (index_inc == count_q) begin
`ifdef SEQ_LOOP_EN
                        index_d = '0;
                        state_d = S_READ_PTR_LO;
`else
                        index_d = index_inc;
                        state_d = S_DONE;
`endif
                    end else begin
                        index_d = index_inc;
                        state_d = S_READ_PTR_LO;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                S_FAIL: begin
                    if (start_edge) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode and ROM port arbitration
    always_comb begin
        busy_out       = (state_q != S_IDLE) && (state_q != S_FAIL);
        done_out       = (state_q == S_DONE);
        fail_out       = (state_q == S_FAIL);
        led_out        = (state_q == S_RUN);
        ctrl_start_out = (state_q == S_START) && !abort_req;
        ctrl_abort_out = abort_req;
        code_index_out = index_q;
        ctrl_base_address_out = base_q;
        if (state_q == S_READ_COUNT)       own_addr = TBL_ADDR;
        else if (state_q == S_READ_PTR_HI) own_addr = ptr_addr + ONE_ADDR;
        else                               own_addr = ptr_addr;
        if (state_q == S_WAIT_BUSY || state_q == S_RUN)
            mem_address_out = ctrl_mem_address_in;
        else
            mem_address_out = own_addr;
    end

endmodule
